// File: rtl/wbs_pdm_in_pkg.sv
// Shared constants for the PDM input peripheral.
package wbs_pdm_in_pkg;
  // Register offsets above the per-channel sample registers
  localparam int ADR_STATUS_OFS  = 0;
  localparam int ADR_OVERRUN_OFS = 1;
  localparam int ADR_W           = 4;
endpackage

// File: rtl/wbs_pdm_in_if.sv
// Wishbone-style bus bundle for the PDM input peripheral.
interface wbs_pdm_in_if #(
  parameter int BIT_RESOLUTION = 8
);
  logic                      wb_stb;
  logic                      wb_we;
  logic [3:0]                wb_adr;
  logic [BIT_RESOLUTION-1:0] wb_dat_c;
  logic [BIT_RESOLUTION-1:0] wb_dat_p;
  logic                      wb_ack;

  modport master (output wb_stb, wb_we, wb_adr, wb_dat_c, input wb_dat_p, wb_ack);
  modport slave  (input wb_stb, wb_we, wb_adr, wb_dat_c, output wb_dat_p, wb_ack);
endinterface

// File: rtl/wbs_pdm_in_channel.sv
// One PDM channel: input synchronizer, ones-counter, sample register and flags.
module wbs_pdm_in_channel #(
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pdm_in,
  input  logic             smp,
  input  logic             last,
  input  logic             rd_clr,
  input  logic             ovr_clr,
  output logic [ACC_W-1:0] sample,
  output logic             valid,
  output logic             overrun
);
  logic [1:0]       sync_q, sync_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] sample_q, sample_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic [ACC_W-1:0] acc_sum;

  // Synchronize, accumulate, close the window; window events override clears
  always_comb begin
    sync_d    = {sync_q[0], pdm_in};
    acc_d     = acc_q;
    sample_d  = sample_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    acc_sum   = acc_q + ACC_W'(sync_q[1]);
    if (rd_clr)  valid_d   = 1'b0;
    if (ovr_clr) overrun_d = 1'b0;
    if (smp) begin
      if (last) begin
        sample_d = acc_sum;
        acc_d    = '0;
        valid_d  = 1'b1;
        // A read landing on the completion cycle consumed the old sample
        if (valid_q && !rd_clr) overrun_d = 1'b1;
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '0;
      acc_q     <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      acc_q     <= acc_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign sample  = sample_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;
endmodule

// File: rtl/wbs_pdm_in.sv
// PDM microphone receiver: bit clock generation, boxcar decimation, bus registers.
module wbs_pdm_in #(
  parameter int BIT_RESOLUTION = 8,
  parameter int CHANNEL_NUM    = 1,
  parameter int DECIMATION     = 255,
  parameter int CLK_DIV        = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  wbs_pdm_in_if.slave            wb,
  output logic                   pdm_clk,
  input  logic [CHANNEL_NUM-1:0] pdm_channel
);
  import wbs_pdm_in_pkg::*;

  localparam int ACC_W = $clog2(DECIMATION + 1);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BC_W  = $clog2(DECIMATION);
  localparam logic [3:0] ADR_STATUS  = 4'(CHANNEL_NUM + ADR_STATUS_OFS);
  localparam logic [3:0] ADR_OVERRUN = 4'(CHANNEL_NUM + ADR_OVERRUN_OFS);

  logic [DIV_W-1:0]                    div_cnt_q, div_cnt_d;
  logic                                pdm_clk_q, pdm_clk_d;
  logic [BC_W-1:0]                     bit_cnt_q, bit_cnt_d;
  logic                                ack_q, ack_d;
  logic [BIT_RESOLUTION-1:0]           dat_q, dat_d;
  logic                                smp, last, rd, wr;
  logic [CHANNEL_NUM-1:0]              rd_clr, ovr_clr, valid, overrun;
  logic [CHANNEL_NUM-1:0][ACC_W-1:0]   samples;

  // Divider, bit clock and window position; bits are taken at the end of the low phase
  always_comb begin
    smp       = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    last      = smp && (bit_cnt_q == BC_W'(DECIMATION - 1));
    div_cnt_d = smp ? '0 : div_cnt_q + DIV_W'(1);
    pdm_clk_d = (div_cnt_d < DIV_W'(CLK_DIV / 2));
    bit_cnt_d = bit_cnt_q;
    if (smp) bit_cnt_d = last ? '0 : bit_cnt_q + BC_W'(1);
  end

  // Bus decode, per-channel clear strobes and registered read mux
  always_comb begin
    rd      = wb.wb_stb && !wb.wb_we;
    wr      = wb.wb_stb &&  wb.wb_we;
    ack_d   = wb.wb_stb;
    dat_d   = '0;
    rd_clr  = '0;
    ovr_clr = (wr && wb.wb_adr == ADR_OVERRUN) ? wb.wb_dat_c[CHANNEL_NUM-1:0] : '0;
    for (int i = 0; i < CHANNEL_NUM; i++) begin
      if (rd && wb.wb_adr == 4'(i)) begin
        rd_clr[i] = 1'b1;
        dat_d     = BIT_RESOLUTION'(samples[i]);
      end
    end
    if (rd && wb.wb_adr == ADR_STATUS)  dat_d = BIT_RESOLUTION'(valid);
    if (rd && wb.wb_adr == ADR_OVERRUN) dat_d = BIT_RESOLUTION'(overrun);
  end

  // Top-level registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt_q <= '0;
      pdm_clk_q <= 1'b0;
      bit_cnt_q <= '0;
      ack_q     <= 1'b0;
      dat_q     <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pdm_clk_q <= pdm_clk_d;
      bit_cnt_q <= bit_cnt_d;
      ack_q     <= ack_d;
      dat_q     <= dat_d;
    end
  end

  for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_ch
    wbs_pdm_in_channel #(.ACC_W(ACC_W)) u_ch (
      .clk     (clk),
      .rst     (rst),
      .pdm_in  (pdm_channel[g]),
      .smp     (smp),
      .last    (last),
      .rd_clr  (rd_clr[g]),
      .ovr_clr (ovr_clr[g]),
      .sample  (samples[g]),
      .valid   (valid[g]),
      .overrun (overrun[g])
    );
  end

  // Write data above the channel count has no meaning
  if (CHANNEL_NUM < BIT_RESOLUTION) begin : g_unused
    logic unused_dat;
    assign unused_dat = ^wb.wb_dat_c[BIT_RESOLUTION-1:CHANNEL_NUM];
  end

  assign wb.wb_ack   = ack_q;
  assign wb.wb_dat_p = dat_q;
  assign pdm_clk     = pdm_clk_q;
endmodule

// File: tb/tb_wbs_pdm_in.sv
// Directed bench for wbs_pdm_in with default parameters (8b, 1 ch, 255 bits, div 8).
module tb_wbs_pdm_in;
  logic       clk;
  logic       rst;
  logic       pdm_clk;
  logic [0:0] pdm_channel;
  int         tests = 0;
  int         fails = 0;
  int         cyc;
  int         mode;
  logic [7:0] d;
  logic       k;

  wbs_pdm_in_if #(.BIT_RESOLUTION(8)) wb_if ();

  wbs_pdm_in #(
    .BIT_RESOLUTION(8), .CHANNEL_NUM(1), .DECIMATION(255), .CLK_DIV(8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wb          (wb_if),
    .pdm_clk     (pdm_clk),
    .pdm_channel (pdm_channel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Posedges since reset release; window m completes on posedge 2040*m
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  // Input bit for PDM bit index j
  function automatic logic pat(input int m, input int j);
    case (m)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (j % 2) == 0;
      default: return (j % 4) == 0;
    endcase
  endfunction

  // PDM source: bit j is driven mid-period so it is synchronized before sample edge 8*(j+1)
  initial begin
    pdm_channel = '0;
    forever begin
      @(negedge clk);
      if (!rst) pdm_channel = 1'($urandom);
      else if (cyc % 8 == 4) pdm_channel = pat(mode, cyc / 8);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] dd, output logic kk);
    wb_if.wb_stb = 1'b1; wb_if.wb_we = 1'b0; wb_if.wb_adr = a;
    @(negedge clk);
    dd = wb_if.wb_dat_p; kk = wb_if.wb_ack;
    wb_if.wb_stb = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] v, output logic [7:0] dd, output logic kk);
    wb_if.wb_stb = 1'b1; wb_if.wb_we = 1'b1; wb_if.wb_adr = a; wb_if.wb_dat_c = v;
    @(negedge clk);
    dd = wb_if.wb_dat_p; kk = wb_if.wb_ack;
    wb_if.wb_stb = 1'b0; wb_if.wb_we = 1'b0;
  endtask

  initial begin
    logic [3:0] b2b_adr [4];
    logic [7:0] b2b_exp [4];
    rst = 1'b0; mode = 1;
    wb_if.wb_stb = 1'b0; wb_if.wb_we = 1'b0; wb_if.wb_adr = '0; wb_if.wb_dat_c = '0;

    // 1: reset held with random bus activity
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rst_ack", wb_if.wb_ack, 0);
      check("rst_pdm_clk", pdm_clk, 0);
      check("rst_dat", wb_if.wb_dat_p, 0);
      wb_if.wb_stb = 1'($urandom); wb_if.wb_we = 1'($urandom);
      wb_if.wb_adr = 4'($urandom); wb_if.wb_dat_c = 8'($urandom);
    end
    @(negedge clk);
    wb_if.wb_stb = 1'b0; wb_if.wb_we = 1'b0;
    rst = 1'b1;

    // 6: bit clock is 4 high / 4 low
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("pdm_clk_phase", pdm_clk, ((cyc % 8) < 4) ? 1 : 0);
    end
    rd(4'd0, d, k); check("rst_ack_rd", k, 1); check("rst_sample0", d, 0);
    rd(4'd1, d, k); check("rst_status", d, 0);
    rd(4'd2, d, k); check("rst_overrun", d, 0);

    // 2: window 1 all ones
    wait_cyc(2041); mode = 0;
    rd(4'd1, d, k); check("w1_status_set", d, 1);
    rd(4'd0, d, k); check("w1_all_ones", d, 255);
    rd(4'd1, d, k); check("w1_status_clr", d, 0);

    // window 2 all zeros
    wait_cyc(4081); mode = 2;
    rd(4'd0, d, k); check("w2_all_zeros", d, 0);

    // 3: window 3 alternating, bit indices 510..764 -> 128 even indices
    wait_cyc(6121); mode = 3;
    rd(4'd0, d, k); check("w3_alt", d, 128);

    // window 4 25%: indices 765..1019 hold 768..1016 -> 63
    wait_cyc(8161);
    rd(4'd0, d, k); check("w4_quarter", d, 63);

    // 4: windows 5 and 6 left unread -> overrun; window 6 (1276..1528) -> 64
    wait_cyc(12241);
    rd(4'd1, d, k); check("ovr_status", d, 1);
    rd(4'd2, d, k); check("ovr_set", d, 1);
    rd(4'd0, d, k); check("w6_quarter", d, 64);
    wr(4'd2, 8'h01, d, k); check("w1c_ack", k, 1); check("w1c_dat_zero", d, 0);
    rd(4'd2, d, k); check("ovr_cleared", d, 0);

    // 5: window 7 (1532..1784 -> 64) left valid; window 8 all ones completes during a read
    wait_cyc(14281); mode = 1;
    wait_cyc(16319);
    wb_if.wb_stb = 1'b1; wb_if.wb_we = 1'b0; wb_if.wb_adr = 4'd0;
    @(negedge clk);
    wb_if.wb_stb = 1'b0;
    check("coinc_cyc", cyc, 16320);
    check("coinc_old_sample", wb_if.wb_dat_p, 64);
    wr(4'd0, 8'h55, d, k); check("wr_sample_ack", k, 1);

    // 6: back-to-back strobes; valid kept, no overrun, write to sample ignored
    b2b_adr = '{4'd1, 4'd2, 4'd3, 4'd0};
    b2b_exp = '{8'd1, 8'd0, 8'd0, 8'd255};
    wb_if.wb_stb = 1'b1; wb_if.wb_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb_if.wb_adr = b2b_adr[i];
      @(negedge clk);
      check("b2b_ack", wb_if.wb_ack, 1);
      check("b2b_dat", wb_if.wb_dat_p, b2b_exp[i]);
    end
    wb_if.wb_stb = 1'b0;
    @(negedge clk);
    check("ack_drop", wb_if.wb_ack, 0);
    rd(4'd1, d, k); check("final_status", d, 0);
    rd(4'd15, d, k); check("unmapped_ack", k, 1); check("unmapped_dat", d, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
